rr_ppe_grant_ctrl: RTL

- Requester-side controller for the 1024-wide pipelined programmable priority encoder (PPE).
- Accumulates pending request bits and drives the PPE request vector and priority pointer.
- Captures the returned grant index after the fixed PPE latency and presents it downstream over a valid/ready handshake.
- On acceptance, clears the served bit and advances the round-robin pointer to the PPE's index+1 output.

---
 rtl/rr_ppe_grant_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rr_ppe_grant_ctrl.sv
// rr_ppe_grant_ctrl
// Requester-side controller for a pipelined programmable priority encoder.
// Collects request pulses into a pending vector and presents it with a
// round-robin pointer to the PPE. It picks up the PPE result a fixed number
// of cycles later and offers the granted index downstream on valid/ready.
// Optional consistency checking is compiled in when RR_PPE_CHECK_EN is
// defined. That build adds the sticky err output.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no lookup in flight; issue when any bit is pending
// WAIT    | lookup in flight, counting down the PPE pipeline latency
// CAPTURE | PPE result for the issued vector is on ppe_value/ppe_valid
// GRANT   | gnt_idx offered downstream, held until gnt_ready

module rr_ppe_grant_ctrl #(
  parameter int W       = 1024,
  parameter int LOG2W   = 10,
  parameter int PPE_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     req_set,
  output logic [W-1:0]     pending,
  output logic [W-1:0]     ppe_req,
  output logic [LOG2W-1:0] ppe_p_enc,
  input  logic [LOG2W-1:0] ppe_value,
  input  logic [LOG2W-1:0] ppe_value_inc,
  input  logic             ppe_valid,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [LOG2W-1:0] gnt_idx,
`ifdef RR_PPE_CHECK_EN
  output logic             err,
`endif
  output logic             busy
);

  // The counter only has to reach PPE_LAT-1. PPE_LAT >= 2 keeps CW >= 1.
  localparam int CW = $clog2(PPE_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(PPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    GRANT
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [LOG2W-1:0] ptr;
  logic [LOG2W-1:0] nxt_ptr;
  logic [W-1:0]     clr_mask;

  // The PPE samples these every cycle. Only the issue-cycle sample matters.
  assign ppe_req   = pending;
  assign ppe_p_enc = ptr;
  assign busy      = (state != IDLE);

  // One-hot clear of the served bit, only on the accepting handshake
  always_comb begin
    clr_mask = '0;
    if (gnt_valid && gnt_ready) begin
      clr_mask[gnt_idx] = 1'b1;
    end
  end

  // Pending accumulation; a same-cycle set beats the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | req_set;
    end
  end

  // Issue / wait / capture / grant sequencing with registered grant outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      nxt_ptr   <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            cnt   <= CW'(1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CAPTURE: begin
          if (ppe_valid) begin
            gnt_idx   <= ppe_value;
            nxt_ptr   <= ppe_value_inc;
            gnt_valid <= 1'b1;
            state     <= GRANT;
          end else begin
            // The vector drained between issue and capture. Go back and re-evaluate.
            state <= IDLE;
          end
        end
        GRANT: begin
          if (gnt_ready) begin
            gnt_valid <= 1'b0;
            ptr       <= nxt_ptr;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RR_PPE_CHECK_EN
  logic [LOG2W-1:0] value_plus1;
  logic             bad_result;

  // Expected pointer advance and the two PPE sanity conditions
  always_comb begin
    value_plus1 = ppe_value + LOG2W'(1);
    bad_result  = (ppe_valid && !pending[ppe_value]) ||
                  (ppe_value_inc != value_plus1);
  end

  // Sticky error flag. The grant still goes ahead when it fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == CAPTURE && bad_result) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
